// File: rtl/div_bcd_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : div_bcd_formatter
//  Description : Post-divider formatter. Captures a quotient/remainder pair
//                and converts both to packed BCD with a sequential
//                shift-add-3 (double dabble), one bit per clock, both
//                operands in parallel. One conversion in flight at a time,
//                valid/ready handshake on input and output.
//  Optional    : define DIV_BCD_BLANK_EN to add leading-zero blank flags
//                (q_blank / r_blank).
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid/in_ready   - input handshake
//                quotient/remainder  - unsigned operands, in_dz flag
//                out_valid/out_ready - output handshake
//                q_bcd/r_bcd         - packed BCD, digit 0 in [3:0]
//                out_dz              - in_dz captured with the pair
//                q_blank/r_blank     - (DIV_BCD_BLANK_EN) blank flags
//  Revision    : 1.0 - initial release
// ============================================================================
module div_bcd_formatter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    input  logic                  in_dz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  out_dz
`ifdef DIV_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     q_blank,
    output logic [DIGITS-1:0]     r_blank
`endif
);

    localparam int                 C_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH);
    localparam int                 C_BCD_W    = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_q_sh;
    logic [WIDTH-1:0]     r_r_sh;
    logic [C_BCD_W-1:0]   r_q_bcd;
    logic [C_BCD_W-1:0]   r_r_bcd;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_dz;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic [C_BCD_W-1:0]   w_q_next;
    logic [C_BCD_W-1:0]   w_r_next;

    // One double-dabble step: every nibble >= 5 gets +3 (max 12, so no nibble
    // overflow), then the whole accumulator shifts left taking in the next
    // operand bit. The top bit shifted out is always 0 when DIGITS is sized
    // for the full operand range.
    function automatic logic [C_BCD_W-1:0] f_dd_step(
        input logic [C_BCD_W-1:0] bcd,
        input logic               bit_in
    );
        logic [C_BCD_W-1:0] adj;
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
            end
        end
        return {adj[C_BCD_W-2:0], bit_in};
    endfunction

    assign w_q_next = f_dd_step(r_q_bcd, r_q_sh[WIDTH-1]);
    assign w_r_next = f_dd_step(r_r_bcd, r_r_sh[WIDTH-1]);

`ifdef DIV_BCD_BLANK_EN
    logic [DIGITS-1:0] r_q_blank;
    logic [DIGITS-1:0] r_r_blank;

    // Bit i is set when digit i and every digit above it are zero; the
    // units digit is never blanked.
    function automatic logic [DIGITS-1:0] f_blank(input logic [C_BCD_W-1:0] bcd);
        logic [DIGITS-1:0] bl;
        logic              all_zero;
        bl       = '0;
        all_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            all_zero = all_zero & (bcd[4*d +: 4] == 4'd0);
            bl[d]    = all_zero;
        end
        return bl;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_q_sh      <= '0;
            r_r_sh      <= '0;
            r_q_bcd     <= '0;
            r_r_bcd     <= '0;
            r_cnt       <= '0;
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef DIV_BCD_BLANK_EN
            r_q_blank   <= '0;
            r_r_blank   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_q_sh     <= quotient;
                        r_r_sh     <= remainder;
                        r_dz       <= in_dz;
                        r_q_bcd    <= '0;
                        r_r_bcd    <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // All WIDTH bits consumed: the accumulators already hold
                    // the final digits, so this cycle only publishes them.
                    if (r_cnt == C_CNT_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
`ifdef DIV_BCD_BLANK_EN
                        r_q_blank   <= f_blank(r_q_bcd);
                        r_r_blank   <= f_blank(r_r_bcd);
`endif
                    end else begin
                        r_q_bcd <= w_q_next;
                        r_r_bcd <= w_r_next;
                        r_q_sh  <= {r_q_sh[WIDTH-2:0], 1'b0};
                        r_r_sh  <= {r_r_sh[WIDTH-2:0], 1'b0};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // Ready is raised only on the edge leaving DONE, so a
                    // new pair is never taken in the same cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q_bcd     = r_q_bcd;
    assign r_bcd     = r_r_bcd;
    assign out_dz    = r_dz;
`ifdef DIV_BCD_BLANK_EN
    assign q_blank   = r_q_blank;
    assign r_blank   = r_r_blank;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_bcd_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_bcd_formatter
//  Description : Self-checking bench for div_bcd_formatter. Directed cases
//                plus randomized pairs checked against an arithmetic BCD
//                model. Blank flags checked when DIV_BCD_BLANK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_bcd_formatter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  quotient;
    logic [WIDTH-1:0]  remainder;
    logic              in_dz;
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     q_bcd;
    logic [BW-1:0]     r_bcd;
    logic              out_dz;
`ifdef DIV_BCD_BLANK_EN
    logic [DIGITS-1:0] q_blank;
    logic [DIGITS-1:0] r_blank;
`endif

    int n_total = 0;
    int n_bad   = 0;

    div_bcd_formatter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .in_dz     (in_dz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .out_dz    (out_dz)
`ifdef DIV_BCD_BLANK_EN
        ,
        .q_blank   (q_blank),
        .r_blank   (r_blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: decimal digits by plain division.
    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] res;
        int            p;
        res = '0;
        p   = 1;
        for (int d = 0; d < DIGITS; d++) begin
            res[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return res;
    endfunction

    // Digit i (i>=1) blanked when the value has fewer than i+1 digits.
    function automatic logic [DIGITS-1:0] blank_of(input int v);
        logic [DIGITS-1:0] b;
        int                p;
        b = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. noise: present a different pair throughout the
    // conversion (must be ignored). early: out_ready high before out_valid.
    task automatic convert(input int q, input int r, input bit dz, input int hold,
                           input bit noise, input bit early);
        int            waitc;
        int            lat;
        bit            hold_ok;
        logic [BW-1:0] eq;
        logic [BW-1:0] er;
        eq = to_bcd(q);
        er = to_bcd(r);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            step();
            waitc++;
        end
        check("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        quotient  = WIDTH'(q);
        remainder = WIDTH'(r);
        in_dz     = dz;
        step();
        check("busy_after_accept", in_ready, 0);
        if (noise) begin
            quotient  = WIDTH'(37);
            remainder = WIDTH'(6);
            in_dz     = ~dz;
        end else begin
            in_valid  = 1'b0;
            quotient  = WIDTH'($urandom);
            remainder = WIDTH'($urandom);
        end
        out_ready = early;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        check("latency", lat, WIDTH + 1);
        if (out_valid) begin
            check("q_bcd", q_bcd, eq);
            check("r_bcd", r_bcd, er);
            check("out_dz", out_dz, dz);
            check("done_in_ready", in_ready, 0);
`ifdef DIV_BCD_BLANK_EN
            check("q_blank", q_blank, blank_of(q));
            check("r_blank", r_blank, blank_of(r));
`endif
            if (!early) begin
                hold_ok = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    step();
                    if (!out_valid || q_bcd !== eq || r_bcd !== er || out_dz !== dz || in_ready)
                        hold_ok = 1'b0;
                end
                if (hold > 0) check("hold_stable", hold_ok, 1);
                out_ready = 1'b1;
            end
            step();
            check("release_out_valid", out_valid, 0);
            check("release_in_ready", in_ready, 1);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        quotient  = '0;
        remainder = '0;
        in_dz     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q_bcd", q_bcd, 0);
        check("rst_r_bcd", r_bcd, 0);
        check("rst_out_dz", out_dz, 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(2, 2, 1'b0, 0, 1'b0, 1'b0);
        convert(255, 254, 1'b0, 0, 1'b0, 1'b0);
        convert(0, 0, 1'b0, 0, 1'b0, 1'b0);
        convert(199, 100, 1'b1, 5, 1'b0, 1'b0);
        convert(123, 45, 1'b0, 2, 1'b1, 1'b0);
        convert(37, 6, 1'b0, 0, 1'b0, 1'b0);
        convert(7, 40, 1'b1, 0, 1'b0, 1'b0);
        convert(9, 10, 1'b0, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a conversion.
        in_valid  = 1'b1;
        quotient  = WIDTH'(200);
        remainder = WIDTH'(99);
        in_dz     = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_q_bcd", q_bcd, 0);
        check("midrst_r_bcd", r_bcd, 0);
        check("midrst_out_dz", out_dz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(200, 99, 1'b1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
